// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the receive frame parser: FSM state
// encoding, default frame markers and the frame length.
package rx_frame_pkg;

  typedef enum logic [1:0] {
    HUNT,
    TS,
    PAYLOAD,
    TRAIL
  } state_t;

  localparam logic [15:0] DEF_START_WORD  = 16'hDEAD;
  localparam logic [15:0] DEF_END_WORD    = 16'hBEEF;
  localparam int          DEF_PAYLOAD_LEN = 125;
  // Start + timestamp + payload + trailer.
  localparam int          FRAME_LEN       = DEF_PAYLOAD_LEN + 3;

  function automatic logic link_ok(input logic [1:0] syncstatus,
                                   input logic [1:0] datak);
    return (syncstatus == 2'b11) && (datak == 2'b00);
  endfunction

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
module sat_cnt16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc,
  output logic [15:0] o_cnt
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/rx_frame_parser.sv
// Parses START/timestamp/payload/END frames from a 16-bit transceiver lane.
// Optional frame/error statistics ports are enabled by RX_FRAME_STATS_EN.
module rx_frame_parser
  import rx_frame_pkg::*;
#(
  parameter logic [15:0] START_WORD  = DEF_START_WORD,
  parameter logic [15:0] END_WORD    = DEF_END_WORD,
  parameter int          PAYLOAD_LEN = DEF_PAYLOAD_LEN
) (
  input  logic        rx_std_clkout,
  input  logic        rst_n,
  input  logic [1:0]  rx_syncstatus,
  input  logic [1:0]  rx_datak,
  input  logic [15:0] RX_data,
  output logic        sample_valid,
  output logic [15:0] sample_data,
  output logic [7:0]  sample_idx,
  output logic [15:0] time_stamp,
  output logic        ts_valid,
  output logic        frame_done,
  output logic        frame_err
`ifdef RX_FRAME_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_LEN - 1);

  state_t      r_state, w_state;
  logic [7:0]  r_cnt, w_cnt;
  logic        r_sv, w_sv;
  logic [15:0] r_sd, w_sd;
  logic [7:0]  r_idx, w_idx;
  logic [15:0] r_ts, w_ts;
  logic        r_tsv, w_tsv;
  logic        r_done, w_done;
  logic        r_err, w_err;
  logic        w_link_ok;

  assign w_link_ok = link_ok(rx_syncstatus, rx_datak);

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_sv    = 1'b0;
    w_sd    = r_sd;
    w_idx   = r_idx;
    w_ts    = r_ts;
    w_tsv   = 1'b0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    unique case (r_state)
      HUNT: begin
        if (w_link_ok && (RX_data == START_WORD)) w_state = TS;
      end
      TS: begin
        if (!w_link_ok) begin
          w_err   = 1'b1;
          w_state = HUNT;
        end else begin
          w_ts    = RX_data;
          w_tsv   = 1'b1;
          w_cnt   = '0;
          w_state = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!w_link_ok) begin
          w_err   = 1'b1;
          w_state = HUNT;
        end else begin
          // Marker values are plain data here; only the word count ends payload.
          w_sv  = 1'b1;
          w_sd  = RX_data;
          w_idx = r_cnt;
          if (r_cnt == LAST_IDX) w_state = TRAIL;
          else                   w_cnt   = r_cnt + 8'd1;
        end
      end
      TRAIL: begin
        if (w_link_ok && (RX_data == END_WORD)) w_done = 1'b1;
        else                                    w_err  = 1'b1;
        w_state = HUNT;
      end
      default: w_state = HUNT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge rx_std_clkout or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the async reset clears every output register, so a frame cut by
      // reset leaves no trace and raises no error pulse.
      r_state <= HUNT;
      r_cnt   <= '0;
      r_sv    <= 1'b0;
      r_sd    <= '0;
      r_idx   <= '0;
      r_ts    <= '0;
      r_tsv   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_sv    <= w_sv;
      r_sd    <= w_sd;
      r_idx   <= w_idx;
      r_ts    <= w_ts;
      r_tsv   <= w_tsv;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end

  assign sample_valid = r_sv;
  assign sample_data  = r_sd;
  assign sample_idx   = r_idx;
  assign time_stamp   = r_ts;
  assign ts_valid     = r_tsv;
  assign frame_done   = r_done;
  assign frame_err    = r_err;

`ifdef RX_FRAME_STATS_EN
  sat_cnt16 u_frame_cnt (
    .clk   (rx_std_clkout),
    .rst_n (rst_n),
    .i_inc (r_done),
    .o_cnt (frame_cnt)
  );

  sat_cnt16 u_err_cnt (
    .clk   (rx_std_clkout),
    .rst_n (rst_n),
    .i_inc (r_err),
    .o_cnt (err_cnt)
  );
`endif

endmodule

// File: tb/tb_rx_frame_parser.sv
// Scoreboard bench for rx_frame_parser: the driver queues expected output
// events per word, a negedge monitor pops and compares them.
module tb_rx_frame_parser;
  import rx_frame_pkg::*;

  localparam int PL = DEF_PAYLOAD_LEN;

  typedef enum int {EV_NONE, EV_TS, EV_SAMPLE, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [15:0] data;
    logic [7:0]  idx;
    int          cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rx_syncstatus;
  logic [1:0]  rx_datak;
  logic [15:0] RX_data;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic [7:0]  sample_idx;
  logic [15:0] time_stamp;
  logic        ts_valid;
  logic        frame_done;
  logic        frame_err;
`ifdef RX_FRAME_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;
`endif

  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  ev_t exp_q[$];

  rx_frame_parser dut (
    .rx_std_clkout (clk),
    .rst_n         (rst_n),
    .rx_syncstatus (rx_syncstatus),
    .rx_datak      (rx_datak),
    .RX_data       (RX_data),
    .sample_valid  (sample_valid),
    .sample_data   (sample_data),
    .sample_idx    (sample_idx),
    .time_stamp    (time_stamp),
    .ts_valid      (ts_valid),
    .frame_done    (frame_done),
    .frame_err     (frame_err)
`ifdef RX_FRAME_STATS_EN
    ,
    .frame_cnt     (frame_cnt),
    .err_cnt       (err_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d cycles, required completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [15:0] d, input logic [7:0] i);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.idx  = i;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [15:0] d, input logic [1:0] sync = 2'b11,
                       input logic [1:0] k = 2'b00);
    @(posedge clk);
    #1;
    RX_data       = d;
    rx_syncstatus = sync;
    rx_datak      = k;
  endtask

  // Sends one frame; abort_idx drops sync at that payload word, reset_idx
  // pulls rst_n low in place of that payload word (-1 disables either).
  task automatic send_frame(input logic [15:0] ts, input logic [15:0] base,
                            input logic [15:0] trailer, input int abort_idx = -1,
                            input int reset_idx = -1, input int dead_idx = -1);
    logic [15:0] w;
    drive(DEF_START_WORD);
    drive(ts);
    push(EV_TS, ts, 8'd0);
    for (int i = 0; i < PL; i++) begin
      w = (i == dead_idx) ? 16'hDEAD : base + 16'(i);
      if (i == reset_idx) begin
        @(posedge clk);
        #6;
        rst_n = 1'b0;
        return;
      end
      if (i == abort_idx) begin
        drive(w, 2'b01);
        push(EV_ERR, 16'd0, 8'd0);
        return;
      end
      drive(w);
      push(EV_SAMPLE, w, 8'(i));
    end
    drive(trailer);
    push((trailer == DEF_END_WORD) ? EV_DONE : EV_ERR, 16'd0, 8'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(16'h0000);
  endtask

  // Monitor: one output event per cycle at most; compare against queue head.
  always @(negedge clk) begin
    ev_kind_t obs;
    ev_t      e;
    if (rst_n === 1'b1) begin
      if (frame_done && frame_err) check("done_err_exclusive", 32'd1, 32'd0);
      obs = sample_valid ? EV_SAMPLE : ts_valid ? EV_TS :
            frame_done ? EV_DONE : frame_err ? EV_ERR : EV_NONE;
      if (obs != EV_NONE) begin
        if (exp_q.size() == 0) begin
          check("spurious_event", 32'(obs), 32'(EV_NONE));
        end else begin
          e = exp_q.pop_front();
          check("event_kind", 32'(obs), 32'(e.kind));
          check("event_latency", 32'(cyc), 32'(e.cyc));
          if (e.kind == EV_SAMPLE) begin
            check("sample_data", {16'd0, sample_data}, {16'd0, e.data});
            check("sample_idx", {24'd0, sample_idx}, {24'd0, e.idx});
          end
          if (e.kind == EV_TS) check("time_stamp", {16'd0, time_stamp}, {16'd0, e.data});
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        check("missing_event", 32'(EV_NONE), 32'(e.kind));
      end
    end
  end

  task automatic check_zero_outputs(input string name);
    check(name, {sample_valid, ts_valid, frame_done, frame_err, sample_data,
                 sample_idx, 4'd0}, 32'd0);
    check({name, "_ts"}, {16'd0, time_stamp}, 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    rx_syncstatus = 2'b00;
    rx_datak      = 2'b00;
    RX_data       = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset_state");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Hunt discards junk, including markers with bad link status.
    drive(16'hBEEF);
    drive(16'hDEAD, 2'b11, 2'b01);
    drive(16'hDEAD, 2'b10);
    drive(16'h1234);

    send_frame(16'h0010, 16'h0000, DEF_END_WORD);
    idle(2);

    // 25 back-to-back frames.
    for (int f = 0; f < 25; f++)
      send_frame(16'(16'h0100 + f), 16'(f * 256), DEF_END_WORD);
    idle(3);
`ifdef RX_FRAME_STATS_EN
    check("frame_cnt_after_b2b", {16'd0, frame_cnt}, 32'd26);
    check("err_cnt_after_b2b", {16'd0, err_cnt}, 32'd0);
`endif

    // Bad trailer, immediately followed by a good frame.
    send_frame(16'h0BAD, 16'h4000, 16'hBEEE);
    send_frame(16'h0C00, 16'h5000, DEF_END_WORD);
    idle(2);

    // Sync loss at payload word 60.
    send_frame(16'h0A5A, 16'h6000, DEF_END_WORD, 60);
    idle(3);
    check("ts_held_after_abort", {16'd0, time_stamp}, 32'h0000_0A5A);
`ifdef RX_FRAME_STATS_EN
    check("err_cnt_after_abort", {16'd0, err_cnt}, 32'd2);
`endif

    // START_WORD value inside payload is plain data.
    send_frame(16'h0D0D, 16'h7000, DEF_END_WORD, -1, -1, 5);
    idle(2);

    // Reset in place of payload word 30, then a full frame.
    send_frame(16'h0E0E, 16'h8000, DEF_END_WORD, -1, 30);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("mid_frame_reset");
    check("queue_empty_at_reset", 32'(exp_q.size()), 32'd0);
`ifdef RX_FRAME_STATS_EN
    check("frame_cnt_reset", {16'd0, frame_cnt}, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(16'h0F0F, 16'h9000, DEF_END_WORD);
    idle(4);
    check("final_time_stamp", {16'd0, time_stamp}, 32'h0000_0F0F);
`ifdef RX_FRAME_STATS_EN
    check("frame_cnt_final", {16'd0, frame_cnt}, 32'd1);
    check("err_cnt_final", {16'd0, err_cnt}, 32'd0);
`endif
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
